instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have these ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- redirect_valid  input  1  core requests a PC change (taken branch, JAL, JALR).
- redirect_pc  input  32  new fetch address when redirect_valid=1.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  instruction memory accepts the request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  instruction memory returns data; returns are in request order and not back-pressurable.
- imem_rsp_data  input  32  returned instruction word.
- instr_valid  output  1  instruction available to the core.
- instr_ready  input  1  core consumes the instruction.
- instr_code  output  32  instruction delivered to the core.
- instr_pc  output  32  address of instr_code.

Function
REQ-003 The block SHALL hold fetch_pc (32 b), a 2-entry in-order FIFO of {pc, instr}, an outstanding-request counter out_cnt (0..2) and a drop counter drop_cnt (0..2).
REQ-004 A request handshake SHALL occur when imem_req_valid=1 and imem_req_ready=1; imem_req_addr SHALL equal fetch_pc; fetch_pc SHALL advance by 4 (mod 2^32) on each handshake.
REQ-005 imem_req_valid SHALL be 1 only when (out_cnt + fifo_count) < 2 and redirect_valid=0 (credit rule; the FIFO never overflows).
REQ-006 imem_req_valid and imem_req_addr SHALL be held stable while imem_req_ready=0, unless a redirect occurs.
REQ-007 out_cnt SHALL increment on a request handshake, decrement on imem_rsp_valid, and stay unchanged when both occur in the same cycle.
REQ-008 On imem_rsp_valid with drop_cnt=0, the response SHALL be written to the FIFO tail with the pc of its matching request; write-to-read latency SHALL be 1 cycle, so instr_valid rises the cycle after the response.
REQ-009 On imem_rsp_valid with drop_cnt>0, the response SHALL be discarded and drop_cnt decremented.
REQ-010 instr_valid SHALL be 1 while the FIFO is non-empty; instr_code/instr_pc SHALL show the FIFO head; the head SHALL be popped on instr_valid & instr_ready.
REQ-011 While instr_valid=0, instr_code SHALL be 32'h0000_0013 (NOP) and instr_pc SHALL be 32'h0.
REQ-012 A simultaneous FIFO push and pop SHALL keep fifo_count unchanged and preserve order.
REQ-013 A redirect cycle (redirect_valid=1) SHALL:
- flush the FIFO;
- suppress imem_req_valid for that cycle;
- set fetch_pc <= {redirect_pc[31:2], 2'b00};
- set drop_cnt to out_cnt after that cycle's update, including any response arriving that cycle, which is also discarded.
REQ-014 A redirect SHALL override a same-cycle pop; instr_ready in that cycle has no effect.
REQ-015 Back-to-back redirects SHALL each apply; the last one determines fetch_pc.
REQ-016 The FSM SHALL have two states:
- FETCH (drop_cnt=0).
- DRAIN (drop_cnt>0): FETCH->DRAIN on a redirect with out_cnt>0; DRAIN->FETCH when drop_cnt reaches 0.
- New requests are permitted in DRAIN under REQ-005.
REQ-017 imem_rsp_valid with out_cnt=0 SHALL be ignored and SHALL change no state.

Reset
REQ-018 While reset=0 at a rising edge, the block SHALL set:
- fetch_pc=RESET_PC, out_cnt=0, drop_cnt=0;
- FIFO empty, state FETCH;
- imem_req_valid=0 in the following cycle, instr_valid=0, instr_code=32'h0000_0013, instr_pc=0.
REQ-019 Reset asserted mid-operation SHALL abandon all in-flight requests; responses arriving after reset deassertion with out_cnt=0 SHALL be ignored per REQ-017.
REQ-020 The first request SHALL be issued in the first cycle after reset deasserts, to address RESET_PC.

Verification
REQ-021 Streaming:
- Stimulus: ready always 1, memory latency 1, instr_ready=1.
- Response: addresses 0,4,8,...; instr_pc matches; instr_code matches memory contents; no gaps after the first delivery.
REQ-022 Back-pressure:
- Stimulus: instr_ready=0 for 10 cycles.
- Response: exactly 2 instructions buffered (pc 0x0, 0x4); imem_req_valid=0; no loss after instr_ready=1.
REQ-023 Redirect with 2 in flight:
- Stimulus: redirect_pc=0x100 while out_cnt=2.
- Response: both stale responses dropped; next delivered instr_pc=0x100.
REQ-024 Misaligned redirect:
- Stimulus: redirect_pc=0x103.
- Response: imem_req_addr=0x100.
REQ-025 Simultaneous redirect and pop:
- Stimulus: redirect_valid=1 and instr_ready=1 with FIFO holding 2 entries.
- Response: FIFO empty next cycle; instr_valid=0; instr_code=32'h0000_0013.
REQ-026 Reset mid-stream:
- Stimulus: reset=0 for 1 cycle with out_cnt=2.
- Response: all outputs at reset values; next request address = RESET_PC; late responses ignored.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side signal bundle: core redirect, instruction-memory request/response
// and the instruction stream handed to the core.
interface instr_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_code;
  logic [31:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr_code, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr_code, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Credit-based instruction fetch: at most two fetches in flight or buffered,
// in-order 2-entry instruction buffer, and stale-response dropping after redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  instr_fetch_unit_if.master        bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;
  logic        head_vld_q, head_vld_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_code_q, head_code_d;
  logic        tail_vld_q, tail_vld_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_code_q, tail_code_d;

  logic [2:0]  credit_used_s;
  logic        redirect_s;
  logic        req_valid_s;
  logic        req_fire_s;
  logic        rsp_fire_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] redirect_target_s;
  logic        unused_pc_bits_s;

  assign unused_pc_bits_s = ^bus.redirect_pc[1:0];

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = head_vld_q;
  assign bus.instr_code     = head_code_q;
  assign bus.instr_pc       = head_pc_q;

  // Handshake qualification; requests are held off while reset is still asserted.
  always_comb begin
    credit_used_s     = {1'b0, out_cnt_q} + {2'b00, head_vld_q} + {2'b00, tail_vld_q};
    redirect_s        = bus.redirect_valid;
    redirect_target_s = {bus.redirect_pc[31:2], 2'b00};
    req_valid_s       = reset & ~redirect_s & (credit_used_s < 3'd2);
    req_fire_s        = req_valid_s & bus.imem_req_ready;
    rsp_fire_s        = bus.imem_rsp_valid & (out_cnt_q != 2'd0);
    push_s            = rsp_fire_s & (state_q == FETCH) & ~redirect_s;
    pop_s             = head_vld_q & bus.instr_ready & ~redirect_s;
  end

  // Counters and PCs; rsp_pc tracks the address of the next response that will be kept.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_cnt_d = drop_cnt_q;
    out_cnt_d  = out_cnt_q + {1'b0, req_fire_s} - {1'b0, rsp_fire_s};
    if (redirect_s) begin
      fetch_pc_d = redirect_target_s;
      rsp_pc_d   = redirect_target_s;
      drop_cnt_d = out_cnt_d;
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (rsp_fire_s && (state_q == DRAIN)) begin
        drop_cnt_d = drop_cnt_q - 2'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (push_s) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end else begin
        rsp_pc_d = rsp_pc_q;
      end
    end
  end

  // Instruction buffer: head slot drives the core outputs directly, shows NOP/0 when empty.
  always_comb begin
    head_vld_d  = head_vld_q;
    head_pc_d   = head_pc_q;
    head_code_d = head_code_q;
    tail_vld_d  = tail_vld_q;
    tail_pc_d   = tail_pc_q;
    tail_code_d = tail_code_q;
    if (redirect_s) begin
      head_vld_d  = 1'b0;
      tail_vld_d  = 1'b0;
      head_pc_d   = 32'h0000_0000;
      head_code_d = NOP;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (head_vld_q) begin
            tail_vld_d  = 1'b1;
            tail_pc_d   = rsp_pc_q;
            tail_code_d = bus.imem_rsp_data;
          end else begin
            head_vld_d  = 1'b1;
            head_pc_d   = rsp_pc_q;
            head_code_d = bus.imem_rsp_data;
          end
        end
        2'b01: begin
          if (tail_vld_q) begin
            head_pc_d   = tail_pc_q;
            head_code_d = tail_code_q;
            tail_vld_d  = 1'b0;
          end else begin
            head_vld_d  = 1'b0;
            head_pc_d   = 32'h0000_0000;
            head_code_d = NOP;
          end
        end
        2'b11: begin
          if (tail_vld_q) begin
            head_pc_d   = tail_pc_q;
            head_code_d = tail_code_q;
            tail_pc_d   = rsp_pc_q;
            tail_code_d = bus.imem_rsp_data;
          end else begin
            head_pc_d   = rsp_pc_q;
            head_code_d = bus.imem_rsp_data;
          end
        end
        default: begin
          head_vld_d = head_vld_q;
        end
      endcase
    end
  end

  // FSM next state: DRAIN while stale responses remain to be discarded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = (drop_cnt_d != 2'd0) ? DRAIN : FETCH;
      DRAIN:   state_d = (drop_cnt_d != 2'd0) ? DRAIN : FETCH;
      default: state_d = FETCH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      out_cnt_q   <= 2'd0;
      drop_cnt_q  <= 2'd0;
      head_vld_q  <= 1'b0;
      head_pc_q   <= 32'h0000_0000;
      head_code_q <= NOP;
      tail_vld_q  <= 1'b0;
      tail_pc_q   <= 32'h0000_0000;
      tail_code_q <= NOP;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      out_cnt_q   <= out_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      head_vld_q  <= head_vld_d;
      head_pc_q   <= head_pc_d;
      head_code_q <= head_code_d;
      tail_vld_q  <= tail_vld_d;
      tail_pc_q   <= tail_pc_d;
      tail_code_q <= tail_code_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenarios plus a randomized run against an address-level model:
// the core must see consecutive words from the last redirect target, each carrying mem_word(pc).
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          delivered = 0;
  int          req_cnt = 0;
  int          base = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          p_ready = 100;
  int          p_iready = 100;
  int          p_redir = 0;
  logic        force_redir = 1'b0;
  logic        force_iready = 1'b0;
  logic        junk_rsp = 1'b0;
  logic [31:0] force_rpc = 32'h0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_req = RESET_PC;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] last_dlv_pc = 32'hFFFF_FFFF;
  logic        hold_prev = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.instr_ready    = 1'b0;
  endtask

  // One-cycle reset pulse; checks reset values and the first request after release.
  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr_code", bus.instr_code, NOP);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    mq.delete();
    last_due = 0;
    req_cnt  = 0;
    exp_pc   = RESET_PC;
    exp_req  = RESET_PC;
    reset    = 1'b1;
    #1;
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, RESET_PC);
    hold_prev = 1'b1;
    prev_addr = bus.imem_req_addr;
  endtask

  task automatic step();
    logic        redir;
    logic [31:0] rpc;
    mem_req_t    e;
    @(negedge clk);
    cyc++;
    redir       = force_redir || ($urandom_range(0, 99) < p_redir);
    rpc         = force_redir ? force_rpc : ($urandom() & 32'h0000_0FFF);
    force_redir = 1'b0;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = ($urandom_range(0, 99) < p_ready);
    bus.instr_ready    = force_iready || ($urandom_range(0, 99) < p_iready);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    #1;
    if (hold_prev && !redir) begin
      chk("hold_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("hold_req_addr", bus.imem_req_addr, prev_addr);
    end
    if (redir) chk("redir_req_suppressed", 32'(bus.imem_req_valid), 32'd0);
    if (!bus.instr_valid) begin
      chk("empty_code_nop", bus.instr_code, NOP);
      chk("empty_pc_zero", bus.instr_pc, 32'h0);
    end
    hold_prev = bus.imem_req_valid && !bus.imem_req_ready;
    prev_addr = bus.imem_req_addr;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("req_addr", bus.imem_req_addr, exp_req);
      e.addr = bus.imem_req_addr;
      e.due  = cyc + int'($urandom_range(lat_min, lat_max));
      if (e.due <= last_due) e.due = last_due + 1;
      last_due = e.due;
      mq.push_back(e);
      chk("in_flight_le_2", 32'(mq.size() > 2), 32'd0);
      exp_req = exp_req + 32'd4;
      req_cnt++;
    end
    if (junk_rsp) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    if (bus.instr_valid && bus.instr_ready && !redir) begin
      chk("dlv_pc", bus.instr_pc, exp_pc);
      chk("dlv_code", bus.instr_code, mem_word(exp_pc));
      last_dlv_pc = bus.instr_pc;
      exp_pc      = exp_pc + 32'd4;
      delivered++;
    end
    if (redir) begin
      exp_pc  = {rpc[31:2], 2'b00};
      exp_req = {rpc[31:2], 2'b00};
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();

    // Streaming, one-cycle memory: two credits over a three-cycle loop give >= 2/3 throughput.
    do_reset();
    repeat (3) step();
    base = delivered;
    repeat (30) step();
    chk("stream_throughput", 32'((delivered - base) >= 18), 32'd1);

    // Back-pressure: exactly two words buffered, no further requests.
    do_reset();
    p_iready = 0;
    repeat (10) step();
    chk("bp_instr_valid", 32'(bus.instr_valid), 32'd1);
    chk("bp_head_pc", bus.instr_pc, 32'h0);
    chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("bp_req_count", 32'(req_cnt), 32'd2);
    p_iready = 100;
    base = delivered;
    repeat (6) step();
    chk("bp_release", 32'((delivered - base) >= 2), 32'd1);

    // Redirect with a full buffer and a same-cycle pop.
    p_iready = 0;
    repeat (10) step();
    chk("full_before_redir", 32'(bus.instr_valid && !bus.imem_req_valid), 32'd1);
    force_redir  = 1'b1;
    force_rpc    = 32'h0000_0040;
    force_iready = 1'b1;
    step();
    force_iready = 1'b0;
    p_iready = 100;
    step();
    chk("flush_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("flush_instr_code", bus.instr_code, NOP);
    chk("flush_req_addr", bus.imem_req_addr, 32'h0000_0040);

    // Misaligned redirect target.
    repeat (8) step();
    force_redir = 1'b1;
    force_rpc   = 32'h0000_0103;
    step();
    step();
    chk("misalign_req_addr", bus.imem_req_addr, 32'h0000_0100);

    // Redirect with two requests outstanding: both stale responses must be dropped.
    do_reset();
    lat_min = 3;
    lat_max = 3;
    step();
    step();
    chk("two_in_flight", 32'(mq.size()), 32'd2);
    force_redir = 1'b1;
    force_rpc   = 32'h0000_0100;
    step();
    base = delivered;
    for (int i = 0; i < 20 && delivered == base; i++) step();
    chk("redir_dlv_seen", 32'(delivered > base), 32'd1);
    chk("redir_first_pc", last_dlv_pc, 32'h0000_0100);

    // Reset mid-stream with two outstanding; late responses must be ignored.
    do_reset();
    step();
    step();
    chk("rst_two_in_flight", 32'(mq.size()), 32'd2);
    do_reset();
    p_ready  = 0;
    junk_rsp = 1'b1;
    step();
    step();
    junk_rsp = 1'b0;
    chk("late_rsp_ignored", 32'(bus.instr_valid), 32'd0);
    p_ready = 100;
    lat_min = 1;
    base = delivered;
    repeat (12) step();
    chk("post_rst_progress", 32'(delivered > base), 32'd1);

    // Randomized traffic with random stalls, latencies and redirects.
    p_ready  = 70;
    p_iready = 70;
    p_redir  = 4;
    base = delivered;
    repeat (3000) step();
    chk("random_progress", 32'((delivered - base) > 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
